// File: rtl/digit_scan_if.sv
// rtl/digit_scan_if.sv - digit/segment bundle between the display source and digit_scan_driver
interface digit_scan_if #(
  parameter int N_DIGITS = 8,
  parameter int SEL_W    = $clog2(N_DIGITS)
);
  logic                  en;
  logic [4*N_DIGITS-1:0] digits;
  logic [N_DIGITS-1:0]   dp;
  logic [N_DIGITS-1:0]   blank;
  logic [0:N_DIGITS-1]   an;
  logic [6:0]            seg;
  logic                  dp_n;
  logic [SEL_W-1:0]      sel;
  logic                  frame_tick;

  modport master (
    output en, digits, dp, blank,
    input  an, seg, dp_n, sel, frame_tick
  );

  modport slave (
    input  en, digits, dp, blank,
    output an, seg, dp_n, sel, frame_tick
  );
endinterface

// File: rtl/digit_scan_driver.sv
// rtl/digit_scan_driver.sv - time-multiplexed seven-segment scanner with per-frame snapshot
// Optional leading-zero suppression is compiled in with `define LEADING_ZERO_BLANK_EN.
module digit_scan_driver #(
  parameter int N_DIGITS = 8,
  parameter int PRESCALE = 100000,
  parameter int SEL_W    = $clog2(N_DIGITS)
) (
  input logic         clk,
  input logic         reset,
  digit_scan_if.slave dsp
);
  localparam int                PCNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_DIGITS - 1);

  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic                  primed_q, primed_d;
  logic [4*N_DIGITS-1:0] digits_s, digits_d;
  logic [N_DIGITS-1:0]   dp_s, dp_d;
  logic [N_DIGITS-1:0]   blank_s, blank_d;
  logic [0:N_DIGITS-1]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_n_q, dp_n_d;
  logic                  tick_q, tick_d;
  logic                  wrap;
  logic [N_DIGITS-1:0]   hide;
  logic [3:0]            cur;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  lz;
`endif

  function automatic logic [6:0] hex7seg(input logic [3:0] v);
    case (v)
      4'h0: hex7seg = 7'h40;
      4'h1: hex7seg = 7'h79;
      4'h2: hex7seg = 7'h24;
      4'h3: hex7seg = 7'h30;
      4'h4: hex7seg = 7'h19;
      4'h5: hex7seg = 7'h12;
      4'h6: hex7seg = 7'h02;
      4'h7: hex7seg = 7'h78;
      4'h8: hex7seg = 7'h00;
      4'h9: hex7seg = 7'h10;
      4'hA: hex7seg = 7'h08;
      4'hB: hex7seg = 7'h03;
      4'hC: hex7seg = 7'h46;
      4'hD: hex7seg = 7'h21;
      4'hE: hex7seg = 7'h06;
      default: hex7seg = 7'h0E;
    endcase
  endfunction

  always_comb begin
    pcnt_d   = pcnt_q;
    sel_d    = sel_q;
    primed_d = primed_q;
    digits_d = digits_s;
    dp_d     = dp_s;
    blank_d  = blank_s;
    wrap     = 1'b0;

    // The first enabled cycle after reset only primes the snapshot, so digit 0
    // gets a full dwell and is driven first even when PRESCALE is 1.
    if (dsp.en) begin
      if (!primed_q) begin
        primed_d = 1'b1;
      end else if (pcnt_q == PCNT_LAST) begin
        pcnt_d = '0;
        if (sel_q == SEL_LAST) begin
          sel_d = '0;
          wrap  = 1'b1;
        end else begin
          sel_d = sel_q + SEL_W'(1);
        end
      end else begin
        pcnt_d = pcnt_q + PCNT_W'(1);
      end
      if (wrap || !primed_q) begin
        digits_d = dsp.digits;
        dp_d     = dsp.dp;
        blank_d  = dsp.blank;
      end
    end

    hide = blank_d;
`ifdef LEADING_ZERO_BLANK_EN
    lz = 1'b1;
    for (int i = 0; i < N_DIGITS - 1; i++) begin
      if (lz && digits_d[4*i +: 4] == 4'h0 && !dp_d[i]) begin
        hide[i] = 1'b1;
      end else begin
        lz = 1'b0;
      end
    end
`endif

    cur  = digits_d[{sel_d, 2'b00} +: 4];
    an_d = '1;
    if (dsp.en) begin
      an_d[sel_d] = 1'b0;
      seg_d       = hide[sel_d] ? 7'h7F : hex7seg(cur);
      dp_n_d      = hide[sel_d] | ~dp_d[sel_d];
      tick_d      = wrap;
    end else begin
      seg_d  = 7'h7F;
      dp_n_d = 1'b1;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt_q   <= '0;
      sel_q    <= '0;
      primed_q <= 1'b0;
      digits_s <= '0;
      dp_s     <= '0;
      blank_s  <= '0;
      an_q     <= '1;
      seg_q    <= 7'h7F;
      dp_n_q   <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      sel_q    <= sel_d;
      primed_q <= primed_d;
      digits_s <= digits_d;
      dp_s     <= dp_d;
      blank_s  <= blank_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_n_q   <= dp_n_d;
      tick_q   <= tick_d;
    end
  end

  assign dsp.an         = an_q;
  assign dsp.seg        = seg_q;
  assign dsp.dp_n       = dp_n_q;
  assign dsp.sel        = sel_q;
  assign dsp.frame_tick = tick_q;
endmodule
